// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: fault codes, fault type and default NOP word for the instruction fetch memory.
// Defining INSTR_MEM_PARITY_EN widens each stored word by one even-parity bit.
package instr_mem_pkg;

   typedef logic [1:0] fault_t;

   localparam fault_t FLT_OK       = 2'd0;
   localparam fault_t FLT_MISALIGN = 2'd1;
   localparam fault_t FLT_RANGE    = 2'd2;
   localparam fault_t FLT_PARITY   = 2'd3;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

`ifdef INSTR_MEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: unreset word storage with one synchronous write port and one enabled synchronous read port.
// Width includes the parity bit when INSTR_MEM_PARITY_EN is defined.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int WORDS = 256,
   parameter int WIDTH = 32 + PAR_W,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [WORDS];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: loadable instruction memory with valid/ready fetch, address fault checks and 1- or 2-cycle latency.
// Optional INSTR_MEM_PARITY_EN stores and checks an even-parity bit per word.
module instr_fetch_mem
   import instr_mem_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_WORDS = 256,
   parameter int                RD_LAT    = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_instr_o,
   output logic [1:0]        rsp_fault_o,
   input  logic              load_en_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_data_i
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int MEM_W = DATA_W + PAR_W;

   logic              adv, accept, rd_en, par_err, unused_load;
   fault_t            fault_d, s1_fault_q, s1_fault;
   logic              s1_valid_q;
   logic [ADDR_W-3:0] word_addr;
   logic [MEM_W-1:0]  wr_word, rd_word;
   logic [DATA_W-1:0] s1_instr;

   assign adv         = !rsp_valid_o || rsp_ready_i;
   assign req_ready_o = adv && !load_en_i;
   assign accept      = req_valid_i && req_ready_o;
   assign word_addr   = req_addr_i[ADDR_W-1:2];
   assign fault_d     = (req_addr_i[1:0] != 2'b00) ? FLT_MISALIGN :
                        ((word_addr >> IDX_W) != '0) ? FLT_RANGE : FLT_OK;
   assign rd_en       = accept && (fault_d == FLT_OK);
   // Load address bits outside the word index are deliberately dropped (wrap-around).
   assign unused_load = ^{load_addr_i[ADDR_W-1:IDX_W+2], load_addr_i[1:0]};

`ifdef INSTR_MEM_PARITY_EN
   assign wr_word = {^load_data_i, load_data_i};
   assign par_err = ^rd_word;
`else
   assign wr_word = load_data_i;
   assign par_err = 1'b0;
`endif

   instr_mem_array #(
      .WORDS (MEM_WORDS),
      .WIDTH (MEM_W),
      .AW    (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (load_en_i),
      .waddr_i (load_addr_i[IDX_W+1:2]),
      .wdata_i (wr_word),
      .re_i    (rd_en),
      .raddr_i (req_addr_i[IDX_W+1:2]),
      .rdata_o (rd_word)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_fault_q <= FLT_OK;
      end else if (adv) begin
         s1_valid_q <= accept;
         s1_fault_q <= fault_d;
      end
   end

   // The array read register is not reset, so stage-1 outputs are masked to zero when invalid.
   assign s1_fault = !s1_valid_q ? FLT_OK :
                     (s1_fault_q != FLT_OK) ? s1_fault_q :
                     par_err ? FLT_PARITY : FLT_OK;
   assign s1_instr = !s1_valid_q ? '0 :
                     (s1_fault == FLT_OK) ? rd_word[DATA_W-1:0] : NOP_WORD;

   if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid_q;
      fault_t            s2_fault_q;
      logic [DATA_W-1:0] s2_instr_q;
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_fault_q <= FLT_OK;
            s2_instr_q <= '0;
         end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_fault_q <= s1_fault;
            s2_instr_q <= s1_instr;
         end
      end
      assign rsp_valid_o = s2_valid_q;
      assign rsp_fault_o = s2_fault_q;
      assign rsp_instr_o = s2_instr_q;
   end else begin : g_lat1
      assign rsp_valid_o = s1_valid_q;
      assign rsp_fault_o = s1_fault;
      assign rsp_instr_o = s1_instr;
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed checks of instr_fetch_mem, driving RD_LAT=1 and RD_LAT=2 instances side by side.
module tb_instr_fetch_mem;

   logic        clk = 1'b0;
   logic        rst_n, rsp_ready, load_en;
   logic [1:0]  req_valid, req_ready, rsp_valid;
   logic [31:0] req_addr [2];
   logic [31:0] rsp_instr [2];
   logic [1:0]  rsp_fault [2];
   logic [31:0] load_addr, load_data;

   typedef struct {
      int          d;
      logic [31:0] instr;
      logic [1:0]  flt;
      int          cyc;
   } rsp_t;

   rsp_t        rq [$];
   logic [31:0] req_list [$];
   int          ptr [2];
   int          first_acc [2];
   int          cyc, n_chk, n_pass;

   always #5 clk = ~clk;

   instr_fetch_mem #(.RD_LAT(1), .NOP_WORD(32'h13)) u_lat1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_addr_i(req_addr[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
      .rsp_instr_o(rsp_instr[0]), .rsp_fault_o(rsp_fault[0]), .load_en_i(load_en),
      .load_addr_i(load_addr), .load_data_i(load_data)
   );

   instr_fetch_mem #(.RD_LAT(2), .NOP_WORD(32'h13)) u_lat2 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_addr_i(req_addr[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
      .rsp_instr_o(rsp_instr[1]), .rsp_fault_o(rsp_fault[1]), .load_en_i(load_en),
      .load_addr_i(load_addr), .load_data_i(load_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = ptr[d] < req_list.size();
         req_addr[d]  = req_valid[d] ? req_list[ptr[d]] : 32'h0;
      end
   endtask

   task automatic step();
      rsp_t r;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rsp_valid[d] && rsp_ready) begin
            r.d = d; r.instr = rsp_instr[d]; r.flt = rsp_fault[d]; r.cyc = cyc;
            rq.push_back(r);
         end
         if (req_valid[d] && req_ready[d]) begin
            if (first_acc[d] < 0) first_acc[d] = cyc;
            ptr[d]++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic go();
      ptr = '{0, 0};
      first_acc = '{-1, -1};
      rq.delete();
      drive();
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] v);
      load_en = 1'b1; load_addr = a; load_data = v;
      #1;
      chk($sformatf("load_ready@%0h", a), {62'd0, req_ready}, 64'd0);
      step();
      load_en = 1'b0;
   endtask

   task automatic out_chk(input string tag, input logic v, input logic [31:0] i, input logic [1:0] f);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s valid lat%0d", tag, d + 1), rsp_valid[d], v);
         chk($sformatf("%s instr lat%0d", tag, d + 1), rsp_instr[d], i);
         chk($sformatf("%s fault lat%0d", tag, d + 1), rsp_fault[d], f);
      end
   endtask

   task automatic check_stream(input string tag, input int n, input logic [31:0] ei [4],
                               input logic [1:0] ef [4], input bit timed);
      for (int d = 0; d < 2; d++) begin
         int k = 0, c0 = 0, cl = 0;
         foreach (rq[i]) begin
            if (rq[i].d == d) begin
               if (k < n) begin
                  chk($sformatf("%s lat%0d instr%0d", tag, d + 1, k), rq[i].instr, ei[k]);
                  chk($sformatf("%s lat%0d fault%0d", tag, d + 1, k), rq[i].flt, ef[k]);
               end
               if (k == 0) c0 = rq[i].cyc;
               cl = rq[i].cyc;
               k++;
            end
         end
         chk($sformatf("%s lat%0d count", tag, d + 1), k, n);
         if (timed) begin
            chk($sformatf("%s lat%0d latency", tag, d + 1), c0 - first_acc[d], d + 1);
            chk($sformatf("%s lat%0d spacing", tag, d + 1), cl - c0, n - 1);
         end
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      rst_n = 1'b0; rsp_ready = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      req_list.delete();
      go();
      repeat (2) step();
      out_chk("reset", 1'b0, 32'h0, 2'd0);
      rst_n = 1'b1;

      load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33);
      load(32'hC, 32'h44); load(32'h10, 32'h55); load(32'h14, 32'h66);

      req_list = '{32'h0, 32'h4, 32'h8, 32'hC};
      go();
      repeat (8) step();
      check_stream("burst", 4, '{32'h11, 32'h22, 32'h33, 32'h44}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1'b1);

      req_list = '{32'h6, 32'h400, 32'h402};
      go();
      repeat (7) step();
      check_stream("fault", 3, '{32'h13, 32'h13, 32'h13, 32'h0}, '{2'd1, 2'd2, 2'd1, 2'd0}, 1'b1);

      rsp_ready = 1'b0;
      req_list = '{32'h8, 32'hC};
      go();
      repeat (2) step();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            load_en = 1'b1; load_addr = 32'h8; load_data = 32'h99;
         end
         step();
         load_en = 1'b0;
         #1;
         out_chk($sformatf("stall%0d", i), 1'b1, 32'h33, 2'd0);
         chk($sformatf("stall%0d ready", i), {62'd0, req_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
      repeat (5) step();
      check_stream("stall", 2, '{32'h33, 32'h44, 32'h0, 32'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1'b0);

      load_en = 1'b1; load_addr = 32'h10; load_data = 32'hAB;
      req_list = '{32'h10};
      go();
      #1;
      chk("ld_win ready", {62'd0, req_ready}, 64'd0);
      step();
      load_en = 1'b0;
      repeat (4) step();
      check_stream("ld_win", 1, '{32'hAB, 32'h0, 32'h0, 32'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1'b1);

      load(32'h410, 32'h77);
      req_list = '{32'h10};
      go();
      repeat (4) step();
      check_stream("wrap", 1, '{32'h77, 32'h0, 32'h0, 32'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1'b1);

      req_list = '{32'h0, 32'h4, 32'h8, 32'hC};
      go();
      repeat (2) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_list.delete();
      drive();
      #1;
      out_chk("midrst", 1'b0, 32'h0, 2'd0);
      rq.delete();
      repeat (5) step();
      chk("midrst stale", rq.size(), 0);

      req_list = '{32'h4};
      go();
      repeat (4) step();
      check_stream("post_rst", 1, '{32'h22, 32'h0, 32'h0, 32'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, synchronous, loadable instruction memory for the pipelined core. It replaces the combinational word-indexed instruction ROM.
- Fetch side: valid/ready request/response interface with a configurable read latency of 1 or 2 cycles.
- Address checking: misaligned and out-of-range fetches are flagged.
- Program loading: a word-write port loads the program at runtime.
- Placement: sits between the fetch stage's PC logic and the decode stage.

Parameters:
ADDR_W, 32, byte-address width of req_addr
DATA_W, 32, instruction word width
MEM_WORDS, 256, number of words; power of two, 4..65536
RD_LAT, 1, read latency in cycles from request accept to rsp_valid; 1 or 2 only
NOP_WORD, 32'h0000_0000, word returned on any faulted fetch

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when high with req_valid
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  DATA_W  fetched word
rsp_fault  out  2  0 ok, 1 misaligned, 2 out of range, 3 parity (optional feature only)
load_en  in  1  write load_data at load_addr this cycle
load_addr  in  ADDR_W  byte address of load; low 2 bits ignored
load_data  in  DATA_W  word to write

Behaviour:
- Reset: one clock with rst_n=0 applies it, including mid-operation.
  - Clears every pipeline valid bit, so rsp_valid=0, rsp_instr=0, rsp_fault=0.
  - In-flight fetches are dropped. Memory contents are not reset.
- Pipeline and stall:
  - RD_LAT stages; stage 1 is the synchronous array read, stage 2 (RD_LAT=2) is an output register.
  - adv = !rsp_valid || rsp_ready. All stages shift together when adv=1 and hold otherwise.
  - Bubbles propagate as valid=0.
- Handshake:
  - req_ready = adv && !load_en; it is combinational from rsp_valid, rsp_ready and load_en only.
  - A request is accepted when req_valid && req_ready.
  - An accepted request appears on rsp_valid exactly RD_LAT cycles later if rsp_ready stayed high.
  - Throughput is 1 word/cycle with no backpressure.
  - rsp_instr and rsp_fault stay stable while rsp_valid && !rsp_ready.
- Address decode:
  - idx = req_addr >> 2.
  - If req_addr[1:0] != 0: fault=1. Misaligned takes priority over range.
  - Else if idx >= MEM_WORDS: fault=2.
  - Any faulted fetch returns NOP_WORD and does not read the array.
- Load:
  - When load_en=1, writes mem[(load_addr>>2) mod MEM_WORDS] at the clock edge.
  - Upper address bits are ignored (wrap-around).
  - No fetch is accepted that cycle.
  - In-flight fetches already past stage 1 keep their old data.
  - Loads are legal while responses are stalled.
- Simultaneous req_valid and load_en: the load wins, and the request waits with req_ready=0.
- Read of a never-loaded word returns X in simulation; the bench must load first.

Optional Feature:
INSTR_MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed at load.
  - Stage 1 recomputes parity on the read word.
  - On mismatch with no address fault, rsp_fault=3 and rsp_instr=NOP_WORD.
- Undefined: no parity storage, and rsp_fault is never 3.

Decomposition:
- Package instr_mem_pkg holds:
  - fault code constants FLT_OK=0, FLT_MISALIGN=1, FLT_RANGE=2, FLT_PARITY=3;
  - the 2-bit fault typedef;
  - the default NOP constant.
- One sub-module, instr_mem_array:
  - MEM_WORDS x (DATA_W + parity) storage;
  - one synchronous write port, one synchronous read port with read enable;
  - no reset.
- The top holds the handshake, fault decode and output pipeline.

Test Plan:
- Load mem[0..3]=0x11,0x22,0x33,0x44 at 0x0..0xC, then back-to-back fetch 0x0,0x4,0x8,0xC with rsp_ready=1 -> rsp_instr 0x11,0x22,0x33,0x44 on consecutive cycles, first response RD_LAT cycles after first accept, rsp_fault=0 (run with RD_LAT=1 and 2).
- Fetch 0x6 and 0x400 (MEM_WORDS=256) -> rsp_fault=1 then 2, rsp_instr=NOP_WORD both times; fetch 0x402 -> fault=1, showing misaligned priority.
- Hold rsp_ready=0 for 3 cycles with a response pending -> rsp_valid, rsp_instr and rsp_fault stable, req_ready=0; release -> no loss or duplication of the next queued word.
- req_valid=1 and load_en=1 on the same cycle at 0x10 with load_data=0xAB -> req_ready=0, write happens; next cycle fetch 0x10 -> 0xAB. Load at 0x410 -> overwrites word 4 (wrap-around).
- Assert rst_n=0 for one cycle with 2 fetches in flight (RD_LAT=2) -> next cycle rsp_valid=0, rsp_instr=0, and no stale responses appear afterward.
- With INSTR_MEM_PARITY_EN, force-flip one stored bit of word 5 and fetch 0x14 -> rsp_fault=3, rsp_instr=NOP_WORD; without the macro, the same test gives fault=0 and the corrupted word.
